// File: rtl/ofm_pool_relu_pkg.sv
// Shared types and helpers for the OFM post-processing stage (ReLU, requantise, 2x2 max-pool).
package pool_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_IFM_WIDTH  = 16;
  localparam int DEF_OFM_SIZE   = 10;
  localparam int DEF_CO         = 8;
  localparam int DEF_SHIFT      = 8;

  // Quantiser arithmetic width; must exceed DATA_WIDTH so the sign-extension field is non-empty.
  localparam int CALC_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int pool_w(input int ofm);
    return ofm / 2;
  endfunction

  function automatic int cnt_w(input int ofm);
    return $clog2(ofm);
  endfunction

  function automatic int ch_w(input int co);
    return $clog2(co) + 1;
  endfunction

  // ReLU, arithmetic right shift, then clamp to the largest positive ifm_w-bit signed value.
  function automatic logic [CALC_W-1:0] sat_relu_shift(input logic signed [CALC_W-1:0] din,
                                                       input int unsigned shift,
                                                       input int unsigned ifm_w);
    logic [CALC_W-1:0] q;
    logic [CALC_W-1:0] q_max;
    q_max = (CALC_W'(1) << (ifm_w - 1)) - CALC_W'(1);
    if (din[CALC_W-1]) q = '0;
    else               q = din >>> shift;
    if (q > q_max) q = q_max;
    return q;
  endfunction

endpackage

// File: rtl/ofm_pool_relu_if.sv
// Streaming interface: conv psum beats in, pooled ifm beats out.
interface ofm_pool_relu_if
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IFM_WIDTH  = DEF_IFM_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [IFM_WIDTH-1:0]  out_data;
  logic                  out_last;

  modport master (output in_valid, in_data, input out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_last);
endinterface

// File: rtl/ofm_pool_relu_line_buf.sv
// Line buffer holding the horizontal pair maxima of the even row of each pooling window row.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = DEF_OFM_SIZE / 2,
  parameter int WIDTH = DEF_IFM_WIDTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk1,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: no reset on the storage; each entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk1) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // The trailing column of an odd-sized plane can address past the last entry; its read is unused.
  assign o_rdata = ({{(32-AW){1'b0}}, i_addr} < 32'(DEPTH)) ? r_mem[i_addr] : '0;

endmodule

// File: rtl/ofm_pool_relu.sv
// ofm_pool_relu: per-psum ReLU/requantise/saturate, then 2x2 stride-2 max-pool of each OFM plane.
module ofm_pool_relu
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IFM_WIDTH  = DEF_IFM_WIDTH,
  parameter int OFM_SIZE   = DEF_OFM_SIZE,
  parameter int CO         = DEF_CO,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic           clk1,
  input  logic           rst_n,
  input  logic           start,
  output logic           done,
  ofm_pool_relu_if.slave bus
);

  localparam int POOL_W = pool_w(OFM_SIZE);
  localparam int CNT_W  = cnt_w(OFM_SIZE);
  localparam int CH_W   = ch_w(CO);
  localparam int LB_AW  = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  localparam logic [CNT_W-1:0] LAST_RC      = CNT_W'(OFM_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_POOL_RC = CNT_W'(2 * POOL_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(CO - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_col;
  logic [CNT_W-1:0]     r_row;
  logic [CH_W-1:0]      r_ch;
  logic [IFM_WIDTH-1:0] r_h;
  logic [IFM_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_done;

  logic signed [CALC_W-1:0] w_din_ext;
  logic [IFM_WIDTH-1:0]     w_q;
  logic [IFM_WIDTH-1:0]     w_hmax;
  logic [IFM_WIDTH-1:0]     w_lb_rdata;
  logic [IFM_WIDTH-1:0]     w_pool;
  logic [LB_AW-1:0]         w_lb_addr;
  logic                     w_accept;
  logic                     w_lb_we;
  logic                     w_last_beat;
  logic                     w_last_pool;

  assign w_din_ext = {{(CALC_W-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
  assign w_q       = IFM_WIDTH'(sat_relu_shift(w_din_ext, SHIFT, IFM_WIDTH));
  assign w_hmax    = (w_q > r_h) ? w_q : r_h;
  assign w_pool    = (w_lb_rdata > w_hmax) ? w_lb_rdata : w_hmax;

  // start has priority, so a beat coinciding with it is dropped.
  assign w_accept  = (r_state == RUN) && bus.in_valid && !start;

  // An odd column is always inside the pooled area, so floor pooling needs no extra bound check.
  assign w_lb_we   = w_accept && r_col[0] && !r_row[0];
  assign w_lb_addr = LB_AW'(r_col >> 1);

  assign w_last_beat = (r_col == LAST_RC) && (r_row == LAST_RC) && (r_ch == LAST_CH);
  assign w_last_pool = (r_col == LAST_POOL_RC) && (r_row == LAST_POOL_RC) && (r_ch == LAST_CH);

  pool_line_buf #(
    .DEPTH (POOL_W),
    .WIDTH (IFM_WIDTH),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk1    (clk1),
    .i_we    (w_lb_we),
    .i_addr  (w_lb_addr),
    .i_wdata (w_hmax),
    .o_rdata (w_lb_rdata)
  );

  // NOTE: non-blocking assignments so every register sees pre-edge values, as the flops do.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_ch        <= '0;
      r_h         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      if (start) begin
        r_state <= RUN;
        r_col   <= '0;
        r_row   <= '0;
        r_ch    <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          RUN: begin
            if (w_accept) begin
              if (r_col == LAST_RC) begin
                r_col <= '0;
                if (r_row == LAST_RC) begin
                  r_row <= '0;
                  r_ch  <= r_ch + 1'b1;
                end else begin
                  r_row <= r_row + 1'b1;
                end
              end else begin
                r_col <= r_col + 1'b1;
              end

              if (!r_col[0]) begin
                r_h <= w_q;
              end else if (r_row[0]) begin
                r_out_data  <= w_pool;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_pool;
              end

              if (w_last_beat) r_state <= DONE;
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign done          = r_done;

endmodule
